dac_spi_wr: RTL
===============

DAC_SPI_WR -- requirements
Module: dac_spi_wr

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_req  input  1  task request level, held high by the task register until ack.
REQ-005 SHALL have port wr_data  input  24  DAC command word, sampled at acceptance.
REQ-006 SHALL have port sel  input  1  DAC select, sampled at acceptance.
REQ-007 SHALL have port ack  output  1  one-cycle transfer-complete pulse.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port sclk  output  1  SPI clock, idles low.
REQ-010 SHALL have port mosi  output  1  SPI data, MSB first.
REQ-011 SHALL have port cs_n  output  2  active-low chip selects; bit sel is used.

Function
REQ-012 SHALL implement states IDLE, LEAD, SHIFT, TRAIL, GAP, ACK, WAIT_LOW.
REQ-013 IDLE: wr_req high at a rising edge (acceptance edge, cycle 0) SHALL latch wr_data and sel, then move to LEAD.
REQ-014 LEAD: cs_n[sel] SHALL be low from cycle 1 with sclk low for CLK_DIV cycles; mosi SHALL equal latched bit 23.
REQ-015 SHALL shift 24 bits in SHIFT, MSB first; each bit SHALL have sclk high for CLK_DIV cycles, then sclk low for CLK_DIV cycles.
REQ-016 SHALL change mosi only on the cycle sclk rises, so the DAC samples on the falling edge.
REQ-017 SHALL, after the 24th falling edge, hold cs_n low and sclk low for CLK_DIV cycles in TRAIL.
REQ-018 GAP: both cs_n bits SHALL be high for CLK_DIV cycles.
REQ-019 ACK: ack SHALL be high for exactly one cycle, at cycle 51*CLK_DIV+1 after the acceptance edge.
REQ-020 WAIT_LOW: SHALL return to IDLE on the first cycle wr_req is sampled low, preventing a repeat transfer from a stale request.
REQ-021 The unselected cs_n bit SHALL stay high throughout.
REQ-022 SHALL ignore wr_data and sel changes after acceptance.
REQ-023 If wr_req falls mid-transfer, SHALL still complete the transfer and pulse ack; WAIT_LOW then exits on the following cycle.
REQ-024 SHALL use an 8-bit clock-divide counter and a 5-bit bit counter; neither SHALL wrap within a transfer.
REQ-025 At CLK_DIV=1, SCLK SHALL be clk/2 with all state durations scaled per REQ-014..REQ-019.

Reset
REQ-026 SHALL, while rst is low, force state IDLE, ack=0, busy=0, sclk=0, mosi=0, cs_n=2'b11, and clear the latched data.
REQ-027 Reset asserted mid-transfer SHALL deassert cs_n immediately (asynchronously) and SHALL NOT produce ack.
REQ-028 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-029 CLK_DIV=4, wr_data=24'hA5C33C, sel=0, req held until ack -> cs_n=2'b10; 24 sclk pulses; mosi bits A5C33C MSB first at falling edges; ack at cycle 205; busy low after WAIT_LOW.
REQ-030 sel=1, wr_data=24'h000001 -> only cs_n[1] goes low; mosi low until the 24th bit, then high; cs_n[0] stays 1.
REQ-031 wr_data changes to 24'hFFFFFF at cycle 10 of a 24'h123456 transfer -> 24'h123456 shifted.
REQ-032 req held high for 20 cycles after ack -> no second transfer starts; IDLE is entered only after req falls; a new req then starts a transfer.
REQ-033 rst pulled low at cycle 100 of a transfer -> cs_n=2'b11, sclk=0 immediately; no ack; a new transfer after release completes normally.
REQ-034 CLK_DIV=1, wr_data=24'h800000 -> sclk period 2 clk; ack at cycle 52; mosi high only during bit 23.

Source files
------------

// File: rtl/dac_spi_wr.sv
// Single-word SPI write engine for a dual DAC: frames one 24-bit command per
// request, driving mosi on sclk rising edges so the DAC samples on falling edges.
module dac_spi_wr #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [23:0] wr_data,
  input  logic        sel,
  output logic        ack,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic [1:0]  cs_n
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LEAD     = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] TRAIL    = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;
  localparam logic [2:0] WAIT_LOW = 3'd6;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  div_cnt_reg, div_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic        phase_reg, phase_next;
  logic [23:0] shift_reg, shift_next;
  logic        ack_reg, ack_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic [1:0]  cs_n_reg, cs_n_next;
  logic        div_done;

  assign div_done = (div_cnt_reg == 8'd0);

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    phase_next   = phase_reg;
    shift_next   = shift_reg;
    ack_next     = 1'b0;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    cs_n_next    = cs_n_reg;

    case (state_reg)
      IDLE: begin
        if (wr_req) begin
          state_next   = LEAD;
          shift_next   = wr_data;
          div_cnt_next = DIV_LAST;
          mosi_next    = wr_data[23];
          sclk_next    = 1'b0;
          cs_n_next    = sel ? 2'b01 : 2'b10;
        end
      end

      LEAD: begin
        if (div_done) begin
          state_next   = SHIFT;
          div_cnt_next = DIV_LAST;
          bit_cnt_next = 5'd23;
          phase_next   = 1'b1;
          sclk_next    = 1'b1;
          mosi_next    = shift_reg[23];
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      // phase_reg high = sclk high half of a bit; the shift happens on the
      // falling half so the next bit is ready at the following rising edge
      SHIFT: begin
        if (!div_done) begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end else if (phase_reg) begin
          phase_next   = 1'b0;
          sclk_next    = 1'b0;
          div_cnt_next = DIV_LAST;
          shift_next   = {shift_reg[22:0], 1'b0};
        end else if (bit_cnt_reg == 5'd0) begin
          state_next   = TRAIL;
          div_cnt_next = DIV_LAST;
        end else begin
          bit_cnt_next = bit_cnt_reg - 5'd1;
          phase_next   = 1'b1;
          sclk_next    = 1'b1;
          mosi_next    = shift_reg[23];
          div_cnt_next = DIV_LAST;
        end
      end

      TRAIL: begin
        if (div_done) begin
          state_next   = GAP;
          cs_n_next    = 2'b11;
          div_cnt_next = DIV_LAST;
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      GAP: begin
        if (div_done) begin
          state_next = ACK;
          ack_next   = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end
      end

      ACK: begin
        state_next = WAIT_LOW;
      end

      // A request still held from the finished transfer must not restart it
      WAIT_LOW: begin
        if (!wr_req) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        sclk_next  = 1'b0;
        cs_n_next  = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      div_cnt_reg <= 8'd0;
      bit_cnt_reg <= 5'd0;
      phase_reg   <= 1'b0;
      shift_reg   <= 24'd0;
      ack_reg     <= 1'b0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 2'b11;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      phase_reg   <= phase_next;
      shift_reg   <= shift_next;
      ack_reg     <= ack_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      cs_n_reg    <= cs_n_next;
    end
  end

  assign ack  = ack_reg;
  assign busy = (state_reg != IDLE);
  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign cs_n = cs_n_reg;

endmodule
